// File: rtl/wb_gpio_master.sv
// wb_gpio_master: turns valid/ready requests into single Wishbone classic cycles
// and returns rdata/err on a valid/ready response channel, with a stb watchdog.
module wb_gpio_master #(
    parameter int dw      = 32,
    parameter int aw      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [aw-1:0] req_addr_i,
    input  logic [dw-1:0] req_wdata_i,
    input  logic [3:0]    req_sel_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [dw-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    localparam bit WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t r_state, w_next;

    logic          r_live;
    logic          r_we;
    logic [aw-1:0] r_adr;
    logic [dw-1:0] r_dat;
    logic [3:0]    r_sel;
    logic [dw-1:0] r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic          w_acc;
    logic          w_bad;
    logic          w_to;
    logic          w_bus;

    // r_live keeps req_ready_o low while reset is held and until the first clock
    assign req_ready_o = r_live && r_state == IDLE;
    assign w_acc       = req_valid_i && req_ready_o;
    assign w_bad       = req_sel_i == 4'd0 || req_addr_i[1:0] != 2'd0;
    assign w_to        = WD_EN && r_cnt == TLAST;
    assign w_bus       = r_state == BUS;

    assign wb_cyc_o    = w_bus;
    assign wb_stb_o    = w_bus;
    assign wb_we_o     = w_bus && r_we;
    assign wb_adr_o    = w_bus ? r_adr : '0;
    assign wb_dat_o    = w_bus ? r_dat : '0;
    assign wb_sel_o    = w_bus ? r_sel : '0;
    assign rsp_valid_o = r_state == RESP;
    assign rsp_rdata_o = rsp_valid_o ? r_rdata : '0;
    assign rsp_err_o   = rsp_valid_o && r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? (w_bad ? RESP : BUS) : IDLE;
            BUS:     w_next = (wb_err_i || wb_ack_i || w_to) ? RESP : BUS;
            RESP:    w_next = rsp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_acc) begin
                r_we    <= req_we_i;
                r_adr   <= req_addr_i;
                r_dat   <= req_wdata_i;
                r_sel   <= req_sel_i;
                r_rdata <= '0;
                r_err   <= w_bad;
                r_cnt   <= '0;
            end
            if (w_bus) begin
                r_cnt <= r_cnt + CW'(1);
                if (wb_err_i) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end else if (wb_ack_i) begin
                    r_err   <= 1'b0;
                    r_rdata <= r_we ? '0 : wb_dat_i;
                end else if (w_to) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_gpio_master.sv
// tb_wb_gpio_master: directed and random transactions against a GPIO-like slave
// whose wait/ack/err behaviour is chosen per transaction; expectations from a reference model.
module tb_wb_gpio_master;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
    logic [7:0]  req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_sel_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o, wb_dat_o, wb_dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
    logic [7:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;

    int checks = 0, fails = 0;
    int slv_k = 100;
    bit slv_ack = 0, slv_err = 0;
    int stb_cnt = 0;
    logic [31:0] mem [64];
    logic [31:0] refm [64];

    always #5 clk = ~clk;

    wb_gpio_master #(.dw(32), .aw(8), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // slave: terminates on stb cycle slv_k (0-based), combinationally
    assign wb_ack_i = wb_stb_o && slv_ack && stb_cnt == slv_k;
    assign wb_err_i = wb_stb_o && slv_err && stb_cnt == slv_k;
    assign wb_dat_i = wb_stb_o ? mem[wb_adr_o[7:2]] : '0;

    always @(posedge clk) begin
        stb_cnt <= wb_stb_o ? stb_cnt + 1 : 0;
        if (wb_stb_o && wb_ack_i && !wb_err_i && wb_we_o)
            for (int b = 0; b < 4; b++)
                if (wb_sel_o[b]) mem[wb_adr_o[7:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input bit we, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int k, input bit ak, input bit er,
                       input int bp, input bit holdv);
        int n, lat, stbc, cycc, exp_stb, exp_lat;
        bit bad, term, exp_err;
        logic [31:0] exp_rd;
        req_we_i = we; req_addr_i = a; req_wdata_i = d; req_sel_i = s; req_valid_i = 1'b1;
        slv_k = k; slv_ack = ak; slv_err = er;
        n = 0;
        while (!req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("req_ready_before_accept", 32'(req_ready_o), 32'd1);
        @(posedge clk); #1;
        if (!holdv) req_valid_i = 1'b0;
        lat = 1; stbc = 0; cycc = 0;
        while (!rsp_valid_o && lat < 20) begin
            if (wb_cyc_o) cycc++;
            if (wb_stb_o) begin
                stbc++;
                chk("wb_adr", 32'(wb_adr_o), 32'(a));
                chk("wb_dat", wb_dat_o, d);
                chk("wb_sel", 32'(wb_sel_o), 32'(s));
                chk("wb_we", 32'(wb_we_o), 32'(we));
            end
            @(posedge clk); #1; lat++;
        end
        bad = s == 4'd0 || a[1:0] != 2'd0;
        term = (ak || er) && k < TO;
        exp_stb = bad ? 0 : (term ? k + 1 : TO);
        exp_lat = exp_stb + 1;
        exp_err = bad || er || !term;
        exp_rd = (!bad && !we && term && ak && !er) ? refm[a[7:2]] : 32'd0;
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("stb_cycles", 32'(stbc), 32'(exp_stb));
        chk("cyc_cycles", 32'(cycc), 32'(exp_stb));
        chk("rsp_rdata", rsp_rdata_o, exp_rd);
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
        repeat (bp) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_rdata", rsp_rdata_o, exp_rd);
            chk("bp_err", 32'(rsp_err_o), 32'(exp_err));
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            chk("bp_cyc", 32'(wb_cyc_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0; req_valid_i = 1'b0;
        chk("rsp_valid_after_hs", 32'(rsp_valid_o), 32'd0);
        chk("req_ready_after_hs", 32'(req_ready_o), 32'd1);
        if (!bad && we && term && ak && !er)
            for (int b = 0; b < 4; b++)
                if (s[b]) refm[a[7:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = $urandom; refm[i] = mem[i]; end
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("rst_cyc_stb_we", 32'({wb_cyc_o, wb_stb_o, wb_we_o}), 32'd0);
        chk("rst_adr_sel", 32'({wb_adr_o, wb_sel_o}), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ready_before_first_clk", 32'(req_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(req_ready_o), 32'd1);

        txn(1, 8'h04, 32'hA5A5_0F0F, 4'hF, 0, 1, 0, 0, 0);
        txn(1, 8'h08, 32'h1234_5678, 4'hF, 0, 1, 0, 0, 0);
        txn(0, 8'h08, 32'h0, 4'hF, 2, 1, 0, 0, 0);
        chk("wait_read_data", refm[2], 32'h1234_5678);
        txn(0, 8'h0C, 32'h0, 4'hF, 100, 0, 0, 0, 0);
        txn(0, 8'h04, 32'h0, 4'hF, 0, 1, 0, 0, 0);
        txn(0, 8'h04, 32'h0, 4'hF, 0, 1, 1, 0, 0);
        txn(1, 8'h10, 32'hDEAD_BEEF, 4'h0, 0, 1, 0, 0, 0);
        txn(0, 8'h06, 32'h0, 4'hF, 0, 1, 0, 0, 0);
        txn(1, 8'h14, 32'hCAFE_0001, 4'h3, 1, 1, 0, 5, 1);
        txn(0, 8'h14, 32'h0, 4'hF, 3, 1, 0, 0, 0);

        req_we_i = 1'b0; req_addr_i = 8'h10; req_sel_i = 4'hF; req_valid_i = 1'b1;
        slv_ack = 0; slv_err = 0;
        @(posedge clk); #1; req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_stb", 32'(wb_stb_o), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_drop_cyc", 32'(wb_cyc_o), 32'd0);
        chk("async_drop_stb", 32'(wb_stb_o), 32'd0);
        chk("reset_req_ready", 32'(req_ready_o), 32'd0);
        repeat (2) begin @(posedge clk); #1; chk("reset_no_rsp", 32'(rsp_valid_o), 32'd0); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 32'(req_ready_o), 32'd1);
        chk("post_reset_no_rsp", 32'(rsp_valid_o), 32'd0);
        txn(0, 8'h04, 32'h0, 4'hF, 1, 1, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            logic [3:0] s;
            a = 8'($urandom);
            if ($urandom % 4 != 0) a[1:0] = 2'd0;
            s = ($urandom % 8 == 0) ? 4'd0 : 4'($urandom);
            txn(1'($urandom), a, $urandom, s, int'($urandom_range(0, 5)),
                ($urandom % 8) != 0, ($urandom % 6) == 0, int'($urandom_range(0, 3)),
                1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
